// File: rtl/mem_frame_reader.sv
// mem_frame_reader: streams one frame from RAM port B to the VGA pixel path through a prefetch FIFO.
// Define MEM_FRAME_READER_UNDERRUN_CNT_EN to build the saturating underrun counter.
module mem_frame_reader #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int FRAME_PIXELS = 10000,
    parameter int RD_LATENCY   = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int CONTINUOUS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] pixel,
    output logic              pix_valid,
    output logic              frame_done,
    output logic              underrun,
    output logic [15:0]       underrun_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FP_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state;
    logic [DATA_W-1:0] fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt, inflight;
    logic [RD_LATENCY-1:0] pipe;
    logic [ADDR_W-1:0] idx;
    logic [FP_W-1:0] issued;
    logic run, push, pop, ur, last_idx;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(pipe[i]);
    end

    assign run      = state == RUN;
    assign push     = pipe[RD_LATENCY-1];
    assign pop      = run && pix_ready && fifo_cnt != '0;
    assign ur       = run && pix_ready && fifo_cnt == '0;
    assign last_idx = idx == LAST;
    // Credits cover both buffered and in-flight words, so the FIFO cannot overflow.
    assign mem_rd   = run && !frame_start && (fifo_cnt + inflight) < CNT_W'(FIFO_DEPTH)
                      && (CONTINUOUS != 0 || issued < FP_W'(FRAME_PIXELS));

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_addr   <= '0;
            pixel      <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            pipe       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            idx        <= '0;
            issued     <= '0;
        end else if (frame_start) begin
            state      <= RUN;
            mem_addr   <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            pipe       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            idx        <= '0;
            issued     <= '0;
        end else begin
            pix_valid  <= pop;
            frame_done <= pop && last_idx;
            underrun   <= ur;
            pipe       <= (pipe << 1) | RD_LATENCY'(mem_rd);
            fifo_cnt   <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            if (mem_rd) begin
                mem_addr <= (mem_addr == LAST) ? '0 : mem_addr + 1'b1;
                issued   <= issued + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                pixel  <= fifo[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
                idx    <= last_idx ? '0 : idx + 1'b1;
                if (last_idx && CONTINUOUS == 0) state <= IDLE;
            end
        end
    end

`ifdef MEM_FRAME_READER_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) underrun_cnt <= '0;
        else if (frame_start) underrun_cnt <= '0;
        else if (ur && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
`else
    assign underrun_cnt = '0;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && fifo_cnt == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_mem_frame_reader.sv
// tb_mem_frame_reader: three reader instances (latency 2/3, continuous and single-frame) against a queue-based reference.
module tb_mem_frame_reader;
    localparam int FP = 8;
`ifdef MEM_FRAME_READER_UNDERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, frame_start, pix_ready;
    logic [13:0] m_addr [3];
    logic [31:0] m_rdata [3], m_pix [3];
    logic        m_rd [3], m_pv [3], m_fd [3], m_ur [3];
    logic [15:0] m_uc [3];
    logic [31:0] s_pix [3];
    logic [13:0] s_addr [3];
    logic        s_rd [3], s_pv [3], s_fd [3], s_ur [3];
    logic [15:0] s_uc [3];
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int g, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0d want %0d", name, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int L = (g == 1) ? 3 : 2;
        localparam int C = (g == 2) ? 0 : 1;
        logic [13:0] ap [L];
        bit run, erd, can_pop, e_pv, e_fd, e_ur;
        int nxt, issued, idx, e_uc;
        logic [31:0] e_pix;
        int qa[$], qt[$];

        mem_frame_reader #(.ADDR_W(14), .DATA_W(32), .FRAME_PIXELS(FP), .RD_LATENCY(L),
                           .FIFO_DEPTH(4), .CONTINUOUS(C)) dut (
            .clk(clk), .rst(rst), .frame_start(frame_start), .pix_ready(pix_ready),
            .mem_rdata(m_rdata[g]), .mem_addr(m_addr[g]), .mem_rd(m_rd[g]), .pixel(m_pix[g]),
            .pix_valid(m_pv[g]), .frame_done(m_fd[g]), .underrun(m_ur[g]), .underrun_cnt(m_uc[g]));

        always @(posedge clk) begin
            ap[0] <= m_addr[g];
            for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
        end
        assign m_rdata[g] = 32'(ap[L-1]) * 32'd3;

        always @(negedge clk) begin
            if (!rst) begin
                run = 0; nxt = 0; issued = 0; idx = 0; e_uc = 0; e_pix = 0;
                e_pv = 0; e_fd = 0; e_ur = 0; qa.delete(); qt.delete();
            end
            erd = rst && run && !frame_start && qa.size() < 4 && (C != 0 || issued < FP);
            check("mem_rd", g, m_rd[g], erd);
            check("mem_addr", g, m_addr[g], nxt);
            check("pixel", g, m_pix[g], e_pix);
            check("pix_valid", g, m_pv[g], e_pv);
            check("frame_done", g, m_fd[g], e_fd);
            check("underrun", g, m_ur[g], e_ur);
            check("underrun_cnt", g, m_uc[g], CNT_EN ? e_uc : 0);
            if (rst) begin
                e_pv = 0; e_fd = 0; e_ur = 0;
                if (frame_start) begin
                    run = 1; nxt = 0; issued = 0; idx = 0; e_uc = 0; qa.delete(); qt.delete();
                end else if (run) begin
                    can_pop = pix_ready && qa.size() > 0 && qt[0] <= cyc;
                    if (erd) begin
                        qa.push_back(nxt); qt.push_back(cyc + L + 1);
                        nxt = (nxt + 1) % FP; issued++;
                    end
                    if (can_pop) begin
                        e_pix = 32'(qa.pop_front()) * 3;
                        void'(qt.pop_front());
                        e_pv = 1; e_fd = idx == FP - 1;
                        if (e_fd && C == 0) run = 0;
                        idx = (idx + 1) % FP;
                    end else if (pix_ready) begin
                        e_ur = 1;
                        if (e_uc < 65535) e_uc++;
                    end
                end
            end
        end
    end

    task automatic step(input bit f, input bit p);
        frame_start = f; pix_ready = p;
        @(negedge clk);
        s_pix = m_pix; s_addr = m_addr; s_rd = m_rd; s_pv = m_pv; s_fd = m_fd; s_ur = m_ur; s_uc = m_uc;
        @(posedge clk); #1;
    endtask

    int got[$], ra[$], pos[$];
    int nfd, fdpix, nur, npv, nrd, first_at, post_ur, post_pv, th;
    bit done;

    initial begin
        rst = 1; frame_start = 0; pix_ready = 0;
        #2 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", 0, m_addr[0], 0);
        check("rst_rd", 0, m_rd[0], 0);
        check("rst_pixel", 0, m_pix[0], 0);
        check("rst_valid", 0, m_pv[0], 0);
        check("rst_ucnt", 0, m_uc[0], 0);
        rst = 1;
        step(0, 0);

        // Streaming from cycle 4 with continuous wrap.
        step(1, 0); repeat (3) step(0, 0);
        got.delete(); nfd = 0; fdpix = -1; nur = 0; first_at = -1;
        for (int i = 0; i < 12; i++) begin
            step(0, 1);
            if (s_pv[0]) begin
                if (first_at < 0) first_at = i;
                got.push_back(int'(s_pix[0]));
            end
            if (s_fd[0]) begin nfd++; fdpix = int'(s_pix[0]); end
            if (s_ur[0]) nur++;
        end
        check("t1_count", 0, got.size() >= 9, 1);
        for (int i = 0; i < 9 && i < got.size(); i++) check("t1_pixel", 0, got[i], (i % 8) * 3);
        check("t1_latency", 0, first_at, 1);
        check("t1_done_n", 0, nfd, 1);
        check("t1_done_px", 0, fdpix, 21);
        check("t1_underrun", 0, nur, 0);

        // Backpressure: credit limit caps the prefetch at four reads.
        step(1, 0);
        ra.delete();
        for (int i = 0; i < 20; i++) begin
            step(0, 0);
            if (s_rd[0]) ra.push_back(int'(s_addr[0]));
        end
        check("t2_reads", 0, ra.size(), 4);
        for (int i = 0; i < 4 && i < ra.size(); i++) check("t2_addr", 0, ra[i], i);
        got.delete(); pos.delete();
        for (int i = 0; i < 8; i++) begin
            step(0, 1);
            if (s_pv[0]) begin got.push_back(int'(s_pix[0])); pos.push_back(i); end
        end
        check("t2_count", 0, got.size() >= 4, 1);
        for (int i = 0; i < 4 && i < got.size(); i++) check("t2_pixel", 0, got[i], i * 3);
        if (pos.size() >= 4) check("t2_nogap", 0, pos[3] - pos[0], 3);

        // Early request on the latency-3 instance.
        step(1, 1);
        nur = 0; done = 0;
        for (int i = 0; i < 15 && !done; i++) begin
            step(0, 1);
            if (s_pv[1]) begin
                done = 1;
                check("t3_pixel", 1, s_pix[1], 0);
                check("t3_ucnt", 1, s_uc[1], CNT_EN ? 4 : 0);
            end else if (s_ur[1]) nur++;
        end
        check("t3_found", 1, done, 1);
        check("t3_underruns", 1, nur, 4);

        // Mid-frame restart with reads in flight.
        step(1, 1);
        npv = 0;
        for (int i = 0; i < 20 && npv < 5; i++) begin
            step(0, 1);
            if (s_pv[0]) npv++;
        end
        check("t4_pre", 0, npv, 5);
        step(1, 1);
        step(0, 1);
        check("t4_valid", 0, s_pv[0], 0);
        check("t4_addr", 0, s_addr[0], 0);
        check("t4_rd", 0, s_rd[0], 1);
        first_at = -1;
        for (int i = 0; i < 10 && first_at < 0; i++) begin
            step(0, 1);
            if (s_pv[0]) begin first_at = i; check("t4_pixel", 0, s_pix[0], 0); end
        end
        check("t4_latency", 0, first_at, 3);

        // Single-frame instance stops after one frame.
        step(1, 1);
        nrd = 0; nfd = 0; fdpix = -1; npv = 0; post_ur = 0; post_pv = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 1);
            if (s_rd[2]) nrd++;
            if (nfd > 0 && s_ur[2]) post_ur++;
            if (nfd > 0 && s_pv[2]) post_pv++;
            if (s_pv[2]) npv++;
            if (s_fd[2]) begin nfd++; fdpix = int'(s_pix[2]); end
        end
        check("t5_reads", 2, nrd, 8);
        check("t5_pixels", 2, npv, 8);
        check("t5_done_n", 2, nfd, 1);
        check("t5_done_px", 2, fdpix, 21);
        check("t5_idle_ur", 2, post_ur, 0);
        check("t5_idle_pv", 2, post_pv, 0);

        // Asynchronous reset between edges.
        step(1, 0);
        repeat (6) step(0, 1);
        #3 rst = 0;
        #1;
        check("t6_addr", 0, m_addr[0], 0);
        check("t6_rd", 0, m_rd[0], 0);
        check("t6_pixel", 0, m_pix[0], 0);
        check("t6_valid", 0, m_pv[0], 0);
        check("t6_underrun", 0, m_ur[0], 0);
        check("t6_ucnt", 0, m_uc[0], 0);
        @(posedge clk); #1 rst = 1;
        nrd = 0; nur = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1);
            if (s_rd[0]) nrd++;
            if (s_ur[0] || s_pv[0]) nur++;
        end
        check("t6_idle_rd", 0, nrd, 0);
        check("t6_idle_out", 0, nur, 0);

        // Random traffic checked cycle by cycle against the reference.
        th = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) th = $urandom_range(10, 100);
            step($urandom_range(0, 59) == 0, $urandom_range(0, 99) < th);
        end
        step(0, 0); step(0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_frame_reader.md
Name: mem_frame_reader

Overview:
- Parametrised successor to the frame-memory-to-VGA pixel fetcher.
- Streams one frame of pixels from a synchronous-read frame RAM port B to the VGA pixel path.
- Hides RAM read latency with an internal prefetch FIFO.
- Wraps exactly at the frame boundary, supports restart on frame sync, and flags underruns when the VGA side requests a pixel that is not yet buffered.

Parameters:
- ADDR_W, 14, width of mem_addr.
- DATA_W, 32, pixel/memory word width.
- FRAME_PIXELS, 10000, pixels per frame; legal range 2..2**ADDR_W.
- RD_LATENCY, 1, RAM cycles from address to data; legal range 1..4.
- FIFO_DEPTH, 4, prefetch entries; power of two, 2..16.
- CONTINUOUS, 1, 1 = wrap to address 0 and keep streaming; 0 = stop after one frame.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous active-low reset.
- frame_start, input, 1, one-cycle pulse: begin/restart a frame at pixel 0.
- pix_ready, input, 1, VGA side requests the next pixel this cycle.
- mem_rdata, input, DATA_W, RAM port B read data (q_b).
- mem_addr, output, ADDR_W, RAM port B address.
- mem_rd, output, 1, read issued this cycle.
- pixel, output, DATA_W, current pixel (registered).
- pix_valid, output, 1, pixel was updated this cycle.
- frame_done, output, 1, pulse when pixel FRAME_PIXELS-1 is delivered.
- underrun, output, 1, pulse when pix_ready is high and the FIFO is empty.
- underrun_cnt, output, 16, see Optional Feature.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - mem_addr=0, mem_rd=0, pixel=0, pix_valid=0, frame_done=0, underrun=0, underrun_cnt=0.
  - FIFO empty; in-flight pipe cleared; delivered-pixel index=0.
- States:
  - IDLE: no reads issued; pix_ready is ignored (no underrun).
  - RUN: entered on frame_start.
  - IDLE -> RUN on frame_start.
  - RUN -> IDLE when frame_done fires and CONTINUOUS=0.
- Read issue (RUN only):
  - mem_rd=1 when (fifo_count + inflight) < FIFO_DEPTH and, if CONTINUOUS=0, issued < FRAME_PIXELS.
  - mem_addr is the address of the read issued that cycle; it advances the cycle after each issue.
  - Address FRAME_PIXELS-1 is followed by 0. mem_addr never exceeds FRAME_PIXELS-1.
- Return path:
  - A valid-bit shift register of length RD_LATENCY tracks in-flight reads.
  - mem_rdata is written into the FIFO exactly RD_LATENCY cycles after its mem_rd.
  - Credit accounting guarantees the FIFO never overflows; that is an assertion, not a handled case.
- Delivery:
  - pix_ready=1 with FIFO non-empty: next cycle pixel=FIFO head, pix_valid=1, head popped, index increments (wrapping at FRAME_PIXELS-1 -> 0).
  - pix_ready=1 with FIFO empty (RUN only): next cycle underrun=1, pix_valid=0, pixel holds its previous value, index unchanged.
  - pix_ready=0: pix_valid=0, pixel holds.
  - A push and a pop in the same cycle are both honoured; fifo_count is unchanged.
- frame_done: asserted in the same cycle as the pix_valid that carries index FRAME_PIXELS-1.
- frame_start while in RUN (mid-frame), taking priority over every other event that cycle:
  - FIFO flushed; in-flight valid bits cleared, so returning data is discarded.
  - mem_addr=0; index=0; pixel holds; pix_valid=0 next cycle.
  - Reads from address 0 start on the following cycle.
- Latency from frame_start to the first deliverable pixel: 1 + RD_LATENCY cycles. pix_ready asserted earlier produces underrun pulses.

Optional Feature:
- Macro: MEM_FRAME_READER_UNDERRUN_CNT_EN.
- Defined:
  - underrun_cnt is a 16-bit counter incremented on each underrun pulse.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by frame_start.
- Not defined: no counter logic; underrun_cnt tied to 0. The underrun pulse is still generated.

Test Plan:
1. FRAME_PIXELS=8, RD_LATENCY=2, RAM word = address*3. Pulse frame_start, hold pix_ready=1 from cycle 4.
   -> pix_valid pixels 0,3,6,...,21.
   -> frame_done coincident with pixel 21.
   -> CONTINUOUS=1: next pixel is 0, no underrun.
2. Backpressure: pix_ready=0 for 20 cycles after frame_start.
   -> mem_rd pulses exactly FIFO_DEPTH=4 times (addr 0..3), then stays 0.
   -> Raising pix_ready delivers 0,3,6,9 with no gaps.
3. Early request: pix_ready=1 in the same cycle as frame_start, RD_LATENCY=3.
   -> underrun pulses for 4 cycles; with macro, underrun_cnt=4.
   -> First pix_valid carries pixel 0.
4. Mid-frame restart: frame_start after pixel 4 is delivered, with 2 reads in flight.
   -> In-flight data discarded; next delivered pixel is 0 (value 0); mem_addr restarts at 0.
5. CONTINUOUS=0, FRAME_PIXELS=8.
   -> Exactly 8 mem_rd pulses; frame_done with pixel 21.
   -> Returns to IDLE: pix_ready=1 afterwards gives no underrun and no pix_valid.
6. Async reset asserted mid-stream between clock edges.
   -> All outputs 0 immediately; after release, no mem_rd until frame_start.
